// File: rtl/arp_responder_multi.sv
// arp_responder_multi: answers ARP requests for up to NUM_IP local IPv4
// addresses, queues pending replies in a small FIFO and streams them out.
// Ports: CLK, ARESET_N (async active-low reset)
//        MY_MAC, MY_IPV4, IP_EN            local identity / per-entry enable
//        DATA_VALID_RX, DATA_RX            received frame bytes
//        DATA_VALID_TX, DATA_TX, DATA_ACK_TX  reply byte stream (valid/ack)
//        REPLY_COUNT, DROP_COUNT           saturating status counters
// Option: define ARP_MIN_FRAME_PAD_EN to pad replies to 60 bytes with 0x00.
module arp_responder_multi #(
    parameter int NUM_IP     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                   CLK,
    input  logic                   ARESET_N,
    input  logic [47:0]            MY_MAC,
    input  logic [32*NUM_IP-1:0]   MY_IPV4,
    input  logic [NUM_IP-1:0]      IP_EN,
    input  logic                   DATA_VALID_RX,
    input  logic [7:0]             DATA_RX,
    output logic                   DATA_VALID_TX,
    output logic [7:0]             DATA_TX,
    input  logic                   DATA_ACK_TX,
    output logic [CNT_W-1:0]       REPLY_COUNT,
    output logic [CNT_W-1:0]       DROP_COUNT
);

    localparam int IW = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 48 + 32 + IW;
    localparam logic [5:0] HDR_END = 6'd42;
`ifdef ARP_MIN_FRAME_PAD_EN
    localparam logic [5:0] LAST_IDX = 6'd59;
`else
    localparam logic [5:0] LAST_IDX = 6'd41;
`endif

    function automatic logic [7:0] b48(input logic [47:0] v, input int k);
        return v[8*(5-k) +: 8];
    endfunction

    function automatic logic [7:0] b32(input logic [31:0] v, input int k);
        return v[8*(3-k) +: 8];
    endfunction

    // Fixed ARP/Ethernet header bytes 12..21; byte 21 is the OPER low byte.
    function automatic logic [7:0] hdr(input int k, input logic [7:0] op);
        logic [7:0] r;
        case (k)
            12:      r = 8'h08;
            13:      r = 8'h06;
            14:      r = 8'h00;
            15:      r = 8'h01;
            16:      r = 8'h08;
            17:      r = 8'h00;
            18:      r = 8'h06;
            19:      r = 8'h04;
            20:      r = 8'h00;
            default: r = op;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // RX parser
    // ------------------------------------------------------------------
    logic          armed_q, armed_d;
    logic          rxv_q, rxv_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          bc_q, bc_d;
    logic          uc_q, uc_d;
    logic          hok_q, hok_d;
    logic [47:0]   sha_q, sha_d;
    logic [31:0]   spa_q, spa_d;
    logic [31:0]   tpa_q, tpa_d;
    logic          wr_q, wr_d;
    logic [IW-1:0] widx_q, widx_d;

    logic          byte_v;
    logic          first;
    logic          fall;
    logic [5:0]    ridx;
    logic          hit;
    logic [IW-1:0] midx;

    always_comb begin
        int ri;
        byte_v  = DATA_VALID_RX & armed_q;
        first   = byte_v & ~rxv_q;
        fall    = rxv_q & ~DATA_VALID_RX;
        ridx    = first ? 6'd0 : cnt_q;
        ri      = int'(ridx);
        // After reset, wait for one idle cycle so a partial frame is skipped.
        armed_d = armed_q | ~DATA_VALID_RX;
        rxv_d   = byte_v;
        cnt_d   = cnt_q;
        bc_d    = bc_q;
        uc_d    = uc_q;
        hok_d   = hok_q;
        sha_d   = sha_q;
        spa_d   = spa_q;
        tpa_d   = tpa_q;
        if (byte_v) begin
            if (first) begin
                bc_d  = 1'b1;
                uc_d  = 1'b1;
                hok_d = 1'b1;
            end
            // Count saturates at 42: later bytes are padding/FCS.
            if (ridx != HDR_END) begin
                cnt_d = ridx + 6'd1;
            end
            if (ri < 6) begin
                bc_d = bc_d & (DATA_RX == 8'hFF);
                uc_d = uc_d & (DATA_RX == b48(MY_MAC, ri));
            end else if (ri >= 12 && ri < 22) begin
                hok_d = hok_d & (DATA_RX == hdr(ri, 8'h01));
            end else if (ri >= 22 && ri < 28) begin
                sha_d = {sha_q[39:0], DATA_RX};
            end else if (ri >= 28 && ri < 32) begin
                spa_d = {spa_q[23:0], DATA_RX};
            end else if (ri >= 38 && ri < 42) begin
                tpa_d = {tpa_q[23:0], DATA_RX};
            end
        end
    end

    // Lowest enabled index wins: scan downward so index 0 is applied last.
    always_comb begin
        hit  = 1'b0;
        midx = '0;
        for (int i = NUM_IP - 1; i >= 0; i--) begin
            if (IP_EN[i] && (MY_IPV4[32*i +: 32] == tpa_q)) begin
                hit  = 1'b1;
                midx = IW'(i);
            end
        end
        wr_d   = fall && (cnt_q == HDR_END) && (bc_q || uc_q) && hok_q && hit;
        widx_d = midx;
    end

    // ------------------------------------------------------------------
    // Pending-reply FIFO: {SHA, SPA, match index}
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   fcnt_q, fcnt_d;
    logic          full, empty, push, pop, drop;
    logic [EW-1:0] ent;
    logic [47:0]   ent_sha;
    logic [31:0]   ent_spa;
    logic [IW-1:0] ent_idx;
    logic [31:0]   ent_ip;

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for the incoming request.
    assign full    = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (fcnt_q == '0);
    assign push    = wr_q & ~full;
    assign drop    = wr_q & full;
    assign ent     = mem_q[rp_q];
    assign ent_sha = ent[EW-1 -: 48];
    assign ent_spa = ent[IW +: 32];
    assign ent_idx = ent[IW-1:0];

    always_comb begin
        ent_ip = '0;
        for (int i = 0; i < NUM_IP; i++) begin
            if (ent_idx == IW'(i)) begin
                ent_ip = MY_IPV4[32*i +: 32];
            end
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (push && !pop) begin
            fcnt_d = fcnt_q + 1'b1;
        end else if (pop && !push) begin
            fcnt_d = fcnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wp_q] <= {sha_q, spa_q, widx_q};
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   tidx_q, tidx_d;
    logic [47:0]  rsha_q, rsha_d;
    logic [31:0]  rspa_q, rspa_d;
    logic [47:0]  rmac_q, rmac_d;
    logic [31:0]  rip_q, rip_d;
    logic         rep_inc;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] drp_q, drp_d;

    always_comb begin
        state_d = state_q;
        tidx_d  = tidx_q;
        rsha_d  = rsha_q;
        rspa_d  = rspa_q;
        rmac_d  = rmac_q;
        rip_d   = rip_q;
        rep_inc = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            // Leaving IDLE on the write cycle itself keeps the
            // write-to-first-byte latency at two cycles.
            S_IDLE: begin
                if (!empty || push) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pop     = 1'b1;
                rsha_d  = ent_sha;
                rspa_d  = ent_spa;
                rmac_d  = MY_MAC;
                rip_d   = ent_ip;
                tidx_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (DATA_ACK_TX) begin
                    if (tidx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        rep_inc = 1'b1;
                    end else begin
                        tidx_d = tidx_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rep_d = rep_q;
        drp_d = drp_q;
        if (rep_inc && (rep_q != '1)) begin
            rep_d = rep_q + 1'b1;
        end
        if (drop && (drp_q != '1)) begin
            drp_d = drp_q + 1'b1;
        end
    end

    // Reply byte mux; driven only from registers, so it is stable while
    // the sink stalls.
    always_comb begin
        int k;
        k       = int'(tidx_q);
        DATA_TX = 8'h00;
        if (state_q == S_SEND) begin
            if (k < 6) begin
                DATA_TX = b48(rsha_q, k);
            end else if (k < 12) begin
                DATA_TX = b48(rmac_q, k - 6);
            end else if (k < 22) begin
                DATA_TX = hdr(k, 8'h02);
            end else if (k < 28) begin
                DATA_TX = b48(rmac_q, k - 22);
            end else if (k < 32) begin
                DATA_TX = b32(rip_q, k - 28);
            end else if (k < 38) begin
                DATA_TX = b48(rsha_q, k - 32);
            end else if (k < 42) begin
                DATA_TX = b32(rspa_q, k - 38);
            end
        end
    end

    assign DATA_VALID_TX = (state_q == S_SEND);
    assign REPLY_COUNT   = rep_q;
    assign DROP_COUNT    = drp_q;

    always_ff @(posedge CLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            armed_q <= 1'b0;
            rxv_q   <= 1'b0;
            cnt_q   <= '0;
            bc_q    <= 1'b0;
            uc_q    <= 1'b0;
            hok_q   <= 1'b0;
            sha_q   <= '0;
            spa_q   <= '0;
            tpa_q   <= '0;
            wr_q    <= 1'b0;
            widx_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            fcnt_q  <= '0;
            state_q <= S_IDLE;
            tidx_q  <= '0;
            rsha_q  <= '0;
            rspa_q  <= '0;
            rmac_q  <= '0;
            rip_q   <= '0;
            rep_q   <= '0;
            drp_q   <= '0;
        end else begin
            armed_q <= armed_d;
            rxv_q   <= rxv_d;
            cnt_q   <= cnt_d;
            bc_q    <= bc_d;
            uc_q    <= uc_d;
            hok_q   <= hok_d;
            sha_q   <= sha_d;
            spa_q   <= spa_d;
            tpa_q   <= tpa_d;
            wr_q    <= wr_d;
            widx_q  <= widx_d;
            if (push) begin
                wp_q <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            tidx_q  <= tidx_d;
            rsha_q  <= rsha_d;
            rspa_q  <= rspa_d;
            rmac_q  <= rmac_d;
            rip_q   <= rip_d;
            rep_q   <= rep_d;
            drp_q   <= drp_d;
        end
    end

endmodule

// File: tb/tb_arp_responder_multi.sv
// tb_arp_responder_multi: scoreboard bench for arp_responder_multi.
// Directed ARP frames; expected reply bytes queued at issue, checked by a monitor.
module tb_arp_responder_multi;

`ifdef ARP_MIN_FRAME_PAD_EN
    localparam int RLEN = 60;
`else
    localparam int RLEN = 42;
`endif
    localparam logic [47:0] MAC0  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC1  = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] IP0   = 32'hC0A8_0001;
    localparam logic [31:0] IP1   = 32'hC0A8_0002;
    localparam logic [31:0] IP2   = 32'hC0A8_0003;
    localparam logic [31:0] IP3   = 32'hC0A8_0004;

    logic         CLK = 1'b0;
    logic         ARESET_N;
    logic [47:0]  MY_MAC;
    logic [127:0] MY_IPV4;
    logic [3:0]   IP_EN;
    logic         DATA_VALID_RX;
    logic [7:0]   DATA_RX;
    logic         DATA_VALID_TX;
    logic [7:0]   DATA_TX;
    logic         DATA_ACK_TX;
    logic [15:0]  REPLY_COUNT;
    logic [15:0]  DROP_COUNT;

    arp_responder_multi dut (
        .CLK           (CLK),
        .ARESET_N      (ARESET_N),
        .MY_MAC        (MY_MAC),
        .MY_IPV4       (MY_IPV4),
        .IP_EN         (IP_EN),
        .DATA_VALID_RX (DATA_VALID_RX),
        .DATA_RX       (DATA_RX),
        .DATA_VALID_TX (DATA_VALID_TX),
        .DATA_TX       (DATA_TX),
        .DATA_ACK_TX   (DATA_ACK_TX),
        .REPLY_COUNT   (REPLY_COUNT),
        .DROP_COUNT    (DROP_COUNT)
    );

    always #5 CLK = ~CLK;

    int         n_chk = 0;
    int         n_pass = 0;
    int         n_acc = 0;
    bit         ack_tog = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] fr [0:63];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] gb(input logic [47:0] v, input int n,
                                      input int k);
        return v[8*(n-1-k) +: 8];
    endfunction

    task automatic mk_req(input logic [47:0] dst, input logic [47:0] sha,
                          input logic [31:0] spa, input logic [31:0] tpa,
                          input logic [15:0] oper);
        for (int i = 0; i < 64; i++) fr[i] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            fr[k]      = gb(dst, 6, k);
            fr[6 + k]  = gb(sha, 6, k);
            fr[22 + k] = gb(sha, 6, k);
        end
        fr[12] = 8'h08; fr[13] = 8'h06; fr[14] = 8'h00; fr[15] = 8'h01;
        fr[16] = 8'h08; fr[17] = 8'h00; fr[18] = 8'h06; fr[19] = 8'h04;
        fr[20] = oper[15:8];
        fr[21] = oper[7:0];
        for (int k = 0; k < 4; k++) begin
            fr[28 + k] = gb({16'h0, spa}, 6, k + 2);
            fr[38 + k] = gb({16'h0, tpa}, 6, k + 2);
        end
    endtask

    task automatic push_reply(input logic [47:0] sha, input logic [31:0] spa,
                              input logic [31:0] ip, input logic [47:0] mac);
        for (int k = 0; k < 6; k++) exp_q.push_back(gb(sha, 6, k));
        for (int k = 0; k < 6; k++) exp_q.push_back(gb(mac, 6, k));
        exp_q.push_back(8'h08); exp_q.push_back(8'h06);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        exp_q.push_back(8'h06); exp_q.push_back(8'h04);
        exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        for (int k = 0; k < 6; k++) exp_q.push_back(gb(mac, 6, k));
        for (int k = 0; k < 4; k++) exp_q.push_back(gb({16'h0, ip}, 6, k + 2));
        for (int k = 0; k < 6; k++) exp_q.push_back(gb(sha, 6, k));
        for (int k = 0; k < 4; k++) exp_q.push_back(gb({16'h0, spa}, 6, k + 2));
        for (int k = 42; k < RLEN; k++) exp_q.push_back(8'h00);
    endtask

    // Drives len bytes then one idle cycle; returns #1 after a rising edge.
    task automatic send(input int len);
        for (int j = 0; j < len; j++) begin
            DATA_VALID_RX = 1'b1;
            DATA_RX       = fr[j];
            @(posedge CLK); #1;
        end
        DATA_VALID_RX = 1'b0;
        DATA_RX       = 8'h00;
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(posedge CLK); #1;
            if (exp_q.size() == 0 && !DATA_VALID_TX) break;
        end
        chk({nm, "_done_in_time"}, k < 3000, 1);
        idle(3);
    endtask

    // Monitor: pops the scoreboard on every accepted byte, checks stalls.
    logic       pv = 1'b0;
    logic       pa = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge CLK) begin
        if (ARESET_N) begin
            if (pv && !pa) begin
                chk("hold_valid", DATA_VALID_TX, 1);
                chk("hold_data", DATA_TX, pd);
            end
            if (DATA_VALID_TX && DATA_ACK_TX) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_byte: got %02h expected none",
                             DATA_TX);
                end else begin
                    chk("tx_byte", DATA_TX, exp_q.pop_front());
                end
            end
        end
        pv = ARESET_N && DATA_VALID_TX;
        pa = DATA_ACK_TX;
        pd = DATA_TX;
    end

    initial begin
        forever begin
            @(posedge CLK); #2;
            if (ack_tog) DATA_ACK_TX = ~DATA_ACK_TX;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int k;
        ARESET_N      = 1'b0;
        MY_MAC        = MAC0;
        MY_IPV4       = {IP3, IP2, IP1, IP0};
        IP_EN         = 4'b0011;
        DATA_VALID_RX = 1'b0;
        DATA_RX       = 8'h00;
        DATA_ACK_TX   = 1'b1;
        #2;
        chk("rst_valid", DATA_VALID_TX, 0);
        chk("rst_data", DATA_TX, 0);
        chk("rst_reply", REPLY_COUNT, 0);
        chk("rst_drop", DROP_COUNT, 0);
        idle(3);
        ARESET_N = 1'b1;
        idle(2);

        // Broadcast request for entry 1, sink always ready.
        mk_req(BCAST, 48'h00_11_22_33_44_55, 32'h0A00_0001, IP1, 16'h0001);
        push_reply(48'h00_11_22_33_44_55, 32'h0A00_0001, IP1, MAC0);
        send(42);
        chk("tx_not_early", DATA_VALID_TX, 0);
        idle(1);
        chk("tx_not_early2", DATA_VALID_TX, 0);
        idle(1);
        chk("tx_rise", DATA_VALID_TX, 1);
        wait_idle("bcast");
        chk("reply_cnt1", REPLY_COUNT, 1);

        // Entry 2 disabled: no reply.
        mk_req(BCAST, 48'h00_11_22_33_44_66, 32'h0A00_0002, IP2, 16'h0001);
        send(42);
        idle(20);
        chk("dis_reply", REPLY_COUNT, 1);
        chk("dis_drop", DROP_COUNT, 0);

        // Unicast, padded 60-byte request, ACK toggling, identity changed
        // while the reply is in flight.
        mk_req(MAC0, 48'h00_AB_CD_EF_01_23, 32'h0A00_0003, IP0, 16'h0001);
        push_reply(48'h00_AB_CD_EF_01_23, 32'h0A00_0003, IP0, MAC0);
        ack_tog = 1'b1;
        send(60);
        for (k = 0; k < 50; k++) begin
            if (DATA_VALID_TX) break;
            @(posedge CLK); #1;
        end
        chk("tog_started", k < 50, 1);
        MY_MAC  = MAC1;
        MY_IPV4 = {IP3, IP2, IP1, 32'hDEAD_BEEF};
        wait_idle("toggle");
        ack_tog     = 1'b0;
        DATA_ACK_TX = 1'b1;
        MY_MAC      = MAC0;
        MY_IPV4     = {IP3, IP2, IP1, IP0};
        chk("reply_cnt2", REPLY_COUNT, 2);

        // Frames that must not be answered.
        mk_req(OTHER, 48'h00_11_22_33_44_77, 32'h0A00_0004, IP0, 16'h0001);
        send(42);
        mk_req(BCAST, 48'h00_11_22_33_44_88, 32'h0A00_0005, IP0, 16'h0001);
        send(41);
        mk_req(BCAST, 48'h00_11_22_33_44_99, 32'h0A00_0006, IP1, 16'h0002);
        send(42);
        idle(20);
        chk("reject_reply", REPLY_COUNT, 2);

        // Six back-to-back requests with the sink stalled.
        DATA_ACK_TX = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mk_req(BCAST, 48'h0A_00_00_00_00_00 + 48'(i),
                   32'h0A00_0100 + 32'(i), (i % 2 == 0) ? IP0 : IP1, 16'h0001);
            if (i < 5)
                push_reply(48'h0A_00_00_00_00_00 + 48'(i),
                           32'h0A00_0100 + 32'(i),
                           (i % 2 == 0) ? IP0 : IP1, MAC0);
            send(42);
        end
        idle(5);
        chk("b2b_drop", DROP_COUNT, 1);
        chk("b2b_stalled", DATA_VALID_TX, 1);
        chk("b2b_reply_pre", REPLY_COUNT, 2);
        DATA_ACK_TX = 1'b1;
        wait_idle("b2b");
        chk("b2b_reply", REPLY_COUNT, 7);
        chk("b2b_drop_end", DROP_COUNT, 1);

        // Reset during TX byte 10.
        mk_req(BCAST, 48'h00_55_55_55_55_55, 32'h0A00_0200, IP0, 16'h0001);
        push_reply(48'h00_55_55_55_55_55, 32'h0A00_0200, IP0, MAC0);
        base = n_acc;
        send(42);
        for (k = 0; k < 200; k++) begin
            if (n_acc - base >= 10) break;
            @(posedge CLK); #1;
        end
        chk("txrst_reached", k < 200, 1);
        ARESET_N = 1'b0;
        #1;
        exp_q.delete();
        chk("txrst_valid", DATA_VALID_TX, 0);
        chk("txrst_data", DATA_TX, 0);
        chk("txrst_reply", REPLY_COUNT, 0);
        chk("txrst_drop", DROP_COUNT, 0);
        idle(1);
        ARESET_N = 1'b1;
        idle(2);

        // Reset during RX byte 20, released while the frame continues.
        mk_req(BCAST, 48'h00_66_66_66_66_66, 32'h0A00_0300, IP0, 16'h0001);
        for (int j = 0; j < 42; j++) begin
            DATA_VALID_RX = 1'b1;
            DATA_RX       = fr[j];
            if (j == 20) begin
                ARESET_N = 1'b0;
                #1;
                chk("rxrst_valid", DATA_VALID_TX, 0);
            end
            if (j == 24) ARESET_N = 1'b1;
            @(posedge CLK); #1;
        end
        DATA_VALID_RX = 1'b0;
        DATA_RX       = 8'h00;
        idle(30);
        chk("rxrst_reply", REPLY_COUNT, 0);
        chk("rxrst_idle", DATA_VALID_TX, 0);

        // Normal request after the resets.
        mk_req(BCAST, 48'h00_77_77_77_77_77, 32'h0A00_0400, IP1, 16'h0001);
        push_reply(48'h00_77_77_77_77_77, 32'h0A00_0400, IP1, MAC0);
        send(42);
        wait_idle("post_rst");
        chk("post_rst_reply", REPLY_COUNT, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
